// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   - drain_state_e : 2-bit encoding of the RX-to-stream drain FSM
//   - D_W_DEF       : default byte width
//   - CNT_W_DEF     : default width of the dropped-byte counter
package uart_pkg;

    localparam int D_W_DEF   = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } drain_state_e;

endpackage

// File: rtl/uart_rx_err_status.sv
// Sticky receive-error status with a saturating dropped-byte counter.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clr            : one-cycle clear of flags and counter
//   ovr_set        : a byte was dropped because the FIFO was full
//   ferr_set       : a byte arrived with a stop-bit error
//   drop_inc       : a byte was dropped (at most one increment per byte)
//   overrun_error  : sticky overrun flag
//   frame_error    : sticky frame-error flag
//   drop_cnt       : saturating count of dropped bytes
module uart_rx_err_status
    import uart_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ovr_set,
    input  logic             ferr_set,
    input  logic             drop_inc,
    output logic             overrun_error,
    output logic             frame_error,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             ovr_q,  ovr_d;
    logic             ferr_q, ferr_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [CNT_W-1:0] cnt_base;

    // A set in the same cycle as a clear wins: the clear zeroes the old
    // state first, then the new event is applied on top.
    always_comb begin
        ovr_d    = (ovr_q  & ~clr) | ovr_set;
        ferr_d   = (ferr_q & ~clr) | ferr_set;
        cnt_base = clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (drop_inc && (cnt_base != CNT_MAX)) begin
            cnt_d = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ovr_q  <= ovr_d;
            ferr_q <= ferr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign overrun_error = ovr_q;
    assign frame_error   = ferr_q;
    assign drop_cnt      = cnt_q;

endmodule

// File: rtl/uart_rx_stream_ctrl.sv
// UART receive sequencing: writes received bytes into the RX FIFO, drains
// the FIFO onto an AXI-Stream master under tready backpressure, and keeps
// sticky overrun/frame-error status plus a saturating drop counter.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   rx_en, rx_valid, rx_byte, rx_ferr: deserializer side
//   ff_wr_en, ff_data_in, ff_full    : FIFO write side
//   ff_rd_en, ff_data_out, ff_empty  : FIFO read side (data one cycle after rd)
//   m_axis_data/tvalid/tready        : AXI-Stream master
//   err_clr, overrun_error, frame_error, drop_cnt : status
//   busy                             : drain in progress or FIFO not empty
module uart_rx_stream_ctrl
    import uart_pkg::*;
#(
    parameter int D_W       = D_W_DEF,
    parameter bit DROP_FERR = 1'b1,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_en,
    input  logic             rx_valid,
    input  logic [D_W-1:0]   rx_byte,
    input  logic             rx_ferr,
    output logic             ff_wr_en,
    output logic [D_W-1:0]   ff_data_in,
    input  logic             ff_full,
    output logic             ff_rd_en,
    input  logic [D_W-1:0]   ff_data_out,
    input  logic             ff_empty,
    output logic [D_W-1:0]   m_axis_data,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    input  logic             err_clr,
    output logic             overrun_error,
    output logic             frame_error,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    drain_state_e   state_q;
    logic [D_W-1:0] data_q;
    logic           tvalid_q;
    logic           rd_req;

    // ---------------- write side ----------------
    logic rx_take;
    logic ferr_drop;

    assign rx_take    = rx_en & rx_valid;
    assign ferr_drop  = DROP_FERR & rx_ferr;
    // Uses the current ff_full: a byte arriving while full is dropped even
    // if the drain side reads in the same cycle.
    assign ff_wr_en   = rx_take & ~ff_full & ~ferr_drop;
    assign ff_data_in = rx_byte;

    uart_rx_err_status #(
        .CNT_W (CNT_W)
    ) u_err_status (
        .clk           (clk),
        .rst           (rst),
        .clr           (err_clr),
        .ovr_set       (rx_take & ff_full),
        .ferr_set      (rx_take & rx_ferr),
        .drop_inc      (rx_take & (ff_full | ferr_drop)),
        .overrun_error (overrun_error),
        .frame_error   (frame_error),
        .drop_cnt      (drop_cnt)
    );

    // ---------------- drain side ----------------
    // Read request is combinational so the FIFO sees it in the same cycle the
    // FSM decides to fetch; it is gated by ff_empty so an empty FIFO is never read.
    always_comb begin
        rd_req = 1'b0;
        case (state_q)
            ST_IDLE:  rd_req = ~ff_empty;
            ST_VALID: rd_req = m_axis_tready & ~ff_empty;
            default:  rd_req = 1'b0;
        endcase
    end

    assign ff_rd_en = rd_req & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tvalid_q <= 1'b0;
            data_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rd_req) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    data_q   <= ff_data_out;
                    tvalid_q <= 1'b1;
                    state_q  <= ST_VALID;
                end
                ST_VALID: begin
                    if (m_axis_tready) begin
                        tvalid_q <= 1'b0;
                        state_q  <= rd_req ? ST_FETCH : ST_IDLE;
                    end
                end
                default: begin
                    tvalid_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axis_data   = data_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = (state_q != ST_IDLE) | ~ff_empty;

endmodule

// File: tb/tb_uart_rx_stream_ctrl.sv
module tb_uart_rx_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_en, rx_valid, rx_ferr, err_clr, m_axis_tready;
    logic [7:0] rx_byte;

    // main DUT (DROP_FERR=1, CNT_W=8) with a behavioural FIFO
    logic       ff_wr_en, ff_full, ff_rd_en, ff_empty, m_axis_tvalid;
    logic       overrun_error, frame_error, busy;
    logic [7:0] ff_data_in, ff_data_out, m_axis_data, drop_cnt;

    // second DUT (DROP_FERR=0, CNT_W=2) with directly driven FIFO flags
    logic       ff_wr_en2, ff_full2, ff_rd_en2, ff_empty2, m_axis_tvalid2;
    logic       overrun_error2, frame_error2, busy2;
    logic [7:0] ff_data_in2, ff_data_out2, m_axis_data2;
    logic [1:0] drop_cnt2;

    int n_cmp  = 0;
    int n_fail = 0;
    int hs_cnt = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    uart_rx_stream_ctrl #(.D_W(8), .DROP_FERR(1'b1), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx_valid(rx_valid),
        .rx_byte(rx_byte), .rx_ferr(rx_ferr),
        .ff_wr_en(ff_wr_en), .ff_data_in(ff_data_in), .ff_full(ff_full),
        .ff_rd_en(ff_rd_en), .ff_data_out(ff_data_out), .ff_empty(ff_empty),
        .m_axis_data(m_axis_data), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .err_clr(err_clr),
        .overrun_error(overrun_error), .frame_error(frame_error),
        .drop_cnt(drop_cnt), .busy(busy)
    );

    uart_rx_stream_ctrl #(.D_W(8), .DROP_FERR(1'b0), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx_valid(rx_valid),
        .rx_byte(rx_byte), .rx_ferr(rx_ferr),
        .ff_wr_en(ff_wr_en2), .ff_data_in(ff_data_in2), .ff_full(ff_full2),
        .ff_rd_en(ff_rd_en2), .ff_data_out(ff_data_out2), .ff_empty(ff_empty2),
        .m_axis_data(m_axis_data2), .m_axis_tvalid(m_axis_tvalid2),
        .m_axis_tready(m_axis_tready), .err_clr(err_clr),
        .overrun_error(overrun_error2), .frame_error(frame_error2),
        .drop_cnt(drop_cnt2), .busy(busy2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- FIFO model for the main DUT ----------------
    logic [7:0] fifo_q[$];
    int         fifo_n = 0;
    logic       force_full = 1'b0;

    assign ff_empty = (fifo_n == 0);
    assign ff_full  = force_full | (fifo_n == 16);

    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
            ff_data_out <= 8'h00;
            fifo_n      <= 0;
        end else begin
            if (ff_rd_en) begin
                chk("rd_on_empty", int'(fifo_n == 0), 0);
                if (fifo_q.size() > 0) ff_data_out <= fifo_q.pop_front();
            end
            if (ff_wr_en) fifo_q.push_back(ff_data_in);
            fifo_n <= fifo_q.size();
        end
    end

    // ---------------- stream monitor / scoreboard ----------------
    // tvalid and tready are stable from just after the falling edge up to the
    // next rising edge, so a high pair here is a handshake on that edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && m_axis_tvalid && m_axis_tready) begin
                hs_cnt++;
                $display("stream byte 0x%02h", m_axis_data);
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", int'(m_axis_data), -1);
                end else begin
                    chk("sb_data", int'(m_axis_data), int'(sb_q.pop_front()));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b, input logic ferr,
                        input logic exp_wr, input logic push);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        rx_ferr  = ferr;
        #1;
        $display("rx byte 0x%02h ferr=%0d wr_en=%0d", b, ferr, ff_wr_en);
        chk("wr_en", int'(ff_wr_en), int'(exp_wr));
        if (exp_wr) chk("wr_data", int'(ff_data_in), int'(b));
        if (push) sb_q.push_back(b);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic wait_tvalid();
        int i;
        for (i = 0; i < 20 && !m_axis_tvalid; i++) @(negedge clk);
        if (!m_axis_tvalid) chk("tvalid_timeout", 0, 1);
    endtask

    initial begin
        int hs0;
        rst = 1'b1; rx_en = 1'b1; rx_valid = 1'b0; rx_ferr = 1'b0; rx_byte = 8'h00;
        err_clr = 1'b0; m_axis_tready = 1'b0;
        ff_full2 = 1'b0; ff_empty2 = 1'b1; ff_data_out2 = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tvalid",  int'(m_axis_tvalid), 0);
        chk("rst_data",    int'(m_axis_data),   0);
        chk("rst_flags",   int'({overrun_error, frame_error}), 0);
        chk("rst_drop",    int'(drop_cnt), 0);
        chk("rst_busy",    int'(busy), 0);
        chk("rst_rd_en",   int'(ff_rd_en), 0);
        chk("rst_wr_en",   int'(ff_wr_en), 0);
        rst = 1'b0;

        // basic drain with latency check
        m_axis_tready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b1; rx_byte = 8'h55;
        sb_q.push_back(8'h55);
        #1;
        chk("lat_wr_en", int'(ff_wr_en), 1);
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        chk("lat_rd_en_n1", int'(ff_rd_en), 1);
        chk("lat_tvalid_n1", int'(m_axis_tvalid), 0);
        @(negedge clk);
        chk("lat_tvalid_n2", int'(m_axis_tvalid), 0);
        @(negedge clk);
        chk("lat_tvalid_n3", int'(m_axis_tvalid), 1);
        chk("lat_data_n3", int'(m_axis_data), 8'h55);
        send(8'hA3, 1'b0, 1'b1, 1'b1);
        repeat (6) @(negedge clk);
        chk("basic_flags", int'({overrun_error, frame_error}), 0);

        // backpressure
        m_axis_tready = 1'b0;
        send(8'h3C, 1'b0, 1'b1, 1'b1);
        wait_tvalid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", int'({m_axis_tvalid, m_axis_data}), 9'h13C);
        end
        hs0 = hs_cnt;
        @(negedge clk);
        m_axis_tready = 1'b1;
        @(negedge clk);
        m_axis_tready = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp_one_handshake", hs_cnt - hs0, 1);
        m_axis_tready = 1'b1;

        // overrun and clear priority
        clear_err();
        force_full = 1'b1;
        send(8'h11, 1'b0, 1'b0, 1'b0);
        send(8'h12, 1'b0, 1'b0, 1'b0);
        chk("ovr_flag", int'(overrun_error), 1);
        chk("ovr_ferr_flag", int'(frame_error), 0);
        chk("ovr_drop2", int'(drop_cnt), 2);
        clear_err();
        chk("clr_flag", int'(overrun_error), 0);
        chk("clr_drop", int'(drop_cnt), 0);
        @(negedge clk);
        err_clr = 1'b1; rx_valid = 1'b1; rx_byte = 8'h22;
        @(negedge clk);
        err_clr = 1'b0; rx_valid = 1'b0;
        chk("clr_set_flag", int'(overrun_error), 1);
        chk("clr_set_drop", int'(drop_cnt), 1);
        force_full = 1'b0;
        clear_err();

        // frame error: main drops, second DUT writes and streams it
        @(negedge clk);
        rx_valid = 1'b1; rx_byte = 8'hFF; rx_ferr = 1'b1;
        #1;
        chk("ferr_wr_en", int'(ff_wr_en), 0);
        chk("ferr_wr_en2", int'(ff_wr_en2), 1);
        chk("ferr_data2", int'(ff_data_in2), 8'hFF);
        @(negedge clk);
        rx_valid = 1'b0; rx_ferr = 1'b0;
        chk("ferr_flag", int'(frame_error), 1);
        chk("ferr_drop", int'(drop_cnt), 1);
        chk("ferr_flag2", int'(frame_error2), 1);
        chk("ferr_drop2", int'(drop_cnt2), 0);
        ff_empty2 = 1'b0;
        #1;
        chk("ferr_rd_en2", int'(ff_rd_en2), 1);
        @(negedge clk);
        ff_empty2 = 1'b1; ff_data_out2 = 8'hFF;
        @(negedge clk);
        chk("ferr_stream2", int'({m_axis_tvalid2, m_axis_data2}), 9'h1FF);
        // full and frame error on one byte counts once
        force_full = 1'b1;
        send(8'hEE, 1'b1, 1'b0, 1'b0);
        chk("both_drop", int'(drop_cnt), 2);
        chk("both_ovr", int'(overrun_error), 1);
        force_full = 1'b0;
        clear_err();

        // saturation
        force_full = 1'b1; ff_full2 = 1'b1;
        @(negedge clk);
        rx_valid = 1'b1; rx_byte = 8'h44;
        repeat (5) @(negedge clk);
        chk("sat_drop5", int'(drop_cnt), 5);
        chk("sat_drop2", int'(drop_cnt2), 3);
        repeat (250) @(negedge clk);
        chk("sat_drop255", int'(drop_cnt), 255);
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        chk("sat_hold255", int'(drop_cnt), 255);
        force_full = 1'b0; ff_full2 = 1'b0;
        clear_err();

        // receive disabled
        rx_en = 1'b0;
        send(8'h99, 1'b1, 1'b0, 1'b0);
        send(8'h98, 1'b0, 1'b0, 1'b0);
        chk("dis_flags", int'({overrun_error, frame_error}), 0);
        chk("dis_drop", int'(drop_cnt), 0);
        chk("dis_busy", int'(busy), 0);
        rx_en = 1'b1;

        // reset mid-transfer
        send(8'h5A, 1'b1, 1'b0, 1'b0);
        m_axis_tready = 1'b0;
        send(8'h77, 1'b0, 1'b1, 1'b0);
        wait_tvalid();
        chk("mid_tvalid_pre", int'(m_axis_tvalid), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_tvalid", int'(m_axis_tvalid), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_flags", int'({overrun_error, frame_error}), 0);
        chk("mid_data", int'(m_axis_data), 0);
        rst = 1'b0;
        m_axis_tready = 1'b1;

        repeat (6) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_stream_ctrl.md
# uart_rx_stream_ctrl

Sequencing controller for the UART receive path. It sits between the `uart_rx` deserializer, the RX `fifo` and the AXI-Stream master port. It writes received bytes into the FIFO, drains the FIFO onto AXI-Stream under `m_axis_tready` backpressure, and keeps sticky overrun/frame-error status with a saturating drop counter.

## Interface
- `D_W`, 8, data width in bits
- `DROP_FERR`, 1, 1 = bytes flagged with a frame error are discarded; 0 = they are written to the FIFO
- `CNT_W`, 8, width of the drop counter
- `clk` in 1, system clock
- `rst` in 1, synchronous, active-high reset
- `rx_en` in 1, receive enable; when 0, incoming bytes are ignored and not counted
- `rx_valid` in 1, one-cycle strobe from `uart_rx`: byte complete
- `rx_byte` in D_W, received byte, qualified by `rx_valid`
- `rx_ferr` in 1, stop-bit error for the current byte, qualified by `rx_valid`
- `ff_wr_en` out 1, FIFO write strobe
- `ff_data_in` out D_W, FIFO write data
- `ff_full` in 1, FIFO full
- `ff_rd_en` out 1, FIFO read strobe
- `ff_data_out` in D_W, FIFO read data, valid the cycle after `ff_rd_en`
- `ff_empty` in 1, FIFO empty
- `m_axis_data` out D_W, stream data
- `m_axis_tvalid` out 1, stream valid
- `m_axis_tready` in 1, stream ready
- `err_clr` in 1, one-cycle pulse that clears the sticky status
- `overrun_error` out 1, sticky: a byte was dropped because the FIFO was full
- `frame_error` out 1, sticky: a byte arrived with `rx_ferr`
- `drop_cnt` out CNT_W, saturating count of dropped bytes (overrun plus discarded frame-error bytes)
- `busy` out 1, high when the drain FSM is not in IDLE, or when `ff_empty` is 0

## Operation
- **Write side (combinational strobe, registered status):**
  - `ff_wr_en` = `rx_en & rx_valid & ~ff_full & ~(DROP_FERR & rx_ferr)`.
  - `ff_data_in` = `rx_byte`.
- **Drop:**
  - If `rx_en & rx_valid & ff_full`: set `overrun_error` and increment `drop_cnt`.
  - If `rx_en & rx_valid & rx_ferr`: set `frame_error`. When `DROP_FERR` = 1, also increment `drop_cnt`. A byte that triggers both conditions increments the counter once.
- `drop_cnt` saturates at 2^CNT_W−1 and never wraps.
- **`err_clr`:** clears both flags and `drop_cnt`. If a new error occurs in the same cycle, the set wins: the flag becomes 1 and the counter becomes 1.
- **Simultaneous FIFO read and write while full:** the decision uses the current `ff_full`, so the incoming byte is dropped and counted as an overrun.
- **Drain FSM states:** IDLE, FETCH, VALID.
  - IDLE: if `~ff_empty`, pulse `ff_rd_en` and go to FETCH.
  - FETCH: latch `ff_data_out` into the `m_axis_data` register, set `m_axis_tvalid`, go to VALID.
  - VALID: hold data and `tvalid` until `m_axis_tready`. On the handshake:
    - if `~ff_empty`, pulse `ff_rd_en` in the same cycle and go to FETCH (`tvalid` drops for one cycle);
    - otherwise clear `tvalid` and go to IDLE.
- `m_axis_data` is stable while `tvalid` = 1 and `tready` = 0. `tvalid` never deasserts without a handshake, except on `rst`.
- `ff_rd_en` is never asserted when `ff_empty` = 1.

## Timing
- **Reset values:**
  - outputs: `ff_wr_en`=0, `ff_rd_en`=0, `m_axis_tvalid`=0, `m_axis_data`=0, `overrun_error`=0, `frame_error`=0, `drop_cnt`=0, `busy`=0;
  - FSM: IDLE.
- **Latency:**
  - `rx_valid` to `ff_wr_en`: 0 cycles (same cycle).
  - Byte written at cycle N: FIFO non-empty at N+1, `ff_rd_en` at N+1, `tvalid` at N+3.
- **Throughput:** 1 byte per 2 cycles with `tready` held at 1.
- **Status flags and `drop_cnt`:** update on the clock edge after the triggering `rx_valid`.
- **Reset mid-transfer:** `tvalid` drops on the next edge and the held byte is lost. The FIFO shares `rst`, so its contents are also lost.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding `ST_IDLE`/`ST_FETCH`/`ST_VALID` (2-bit);
  - default `D_W`;
  - default `CNT_W`.
- One natural sub-module: `uart_rx_err_status`, which holds the sticky flags, the saturating `drop_cnt` and the clear-vs-set priority.
- The drain FSM and the write gating stay in the top.

## Test plan
- **Basic drain:** reset; send bytes 0x55, 0xA3 via `rx_valid`; `tready`=1 → stream shows 0x55 then 0xA3, first `tvalid` 3 cycles after the first `rx_valid`, no errors.
- **Backpressure:** hold `tready`=0 for 10 cycles with 0x3C presented → `m_axis_data`=0x3C stable and `tvalid`=1 throughout; after `tready`=1, exactly one handshake.
- **Overrun:** `ff_full`=1 model, two `rx_valid` strobes → `ff_wr_en`=0 both times, `overrun_error`=1, `drop_cnt`=2. Then `err_clr` → both 0. `err_clr` coincident with a third drop → `overrun_error`=1, `drop_cnt`=1.
- **Frame error:** `rx_ferr`=1 with byte 0xFF.
  - `DROP_FERR`=1 → no write, `frame_error`=1, `drop_cnt`=1.
  - `DROP_FERR`=0 → 0xFF appears on the stream, `frame_error`=1, `drop_cnt`=0.
- **Saturation and enable:** `CNT_W`=2, 5 drops → `drop_cnt`=3. With `rx_en`=0, strobes cause no write and no status change.
- **Reset mid-transfer:** `tvalid`=1 with `tready`=0, assert `rst` → next edge `tvalid`=0, FSM IDLE, `busy`=0, all flags 0.
